// File: rtl/rtype_pkg.sv
// Shared encodings for the R-type multicycle sequencer: FSM states,
// MIPS R-type function codes and the ALU control codes they map to.
package rtype_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE  = 6'h00;

    localparam logic [5:0] FUNC_ADD  = 6'h20;
    localparam logic [5:0] FUNC_ADDU = 6'h21;
    localparam logic [5:0] FUNC_SUB  = 6'h22;
    localparam logic [5:0] FUNC_SUBU = 6'h23;
    localparam logic [5:0] FUNC_AND  = 6'h24;
    localparam logic [5:0] FUNC_OR   = 6'h25;
    localparam logic [5:0] FUNC_XOR  = 6'h26;
    localparam logic [5:0] FUNC_NOR  = 6'h27;
    localparam logic [5:0] FUNC_SLT  = 6'h2A;
    localparam logic [5:0] FUNC_SLTU = 6'h2B;

    localparam logic [3:0] ALU_ADD   = 4'b1010;
    localparam logic [3:0] ALU_ADDU  = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b1110;
    localparam logic [3:0] ALU_SUBU  = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b1111;

endpackage

// File: rtl/rtype_multicycle_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and imem (slave).
interface rtype_multicycle_sequencer_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;

    modport master (output imem_req, input  imem_ack, input  imem_data);
    modport slave  (input  imem_req, output imem_ack, output imem_data);
endinterface

// File: rtl/rtype_decode.sv
// Combinational Op/Func decode to a 4-bit ALU control code.
// Anything that is not one of the ten supported R-type ops reports legal=0 and ALUCntl=0.
module rtype_decode
    import rtype_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic       legal,
    output logic [3:0] ALUCntl
);

    logic       hit;
    logic [3:0] code;

    always_comb begin
        hit  = 1'b1;
        code = ALU_AND;
        case (func)
            FUNC_ADD:  code = ALU_ADD;
            FUNC_ADDU: code = ALU_ADDU;
            FUNC_SUB:  code = ALU_SUB;
            FUNC_SUBU: code = ALU_SUBU;
            FUNC_AND:  code = ALU_AND;
            FUNC_OR:   code = ALU_OR;
            FUNC_XOR:  code = ALU_XOR;
            FUNC_NOR:  code = ALU_NOR;
            FUNC_SLT:  code = ALU_SLT;
            FUNC_SLTU: code = ALU_SLTU;
            default:   hit  = 1'b0;
        endcase
    end

    assign legal   = hit && (op == OP_RTYPE);
    assign ALUCntl = legal ? code : 4'b0000;

endmodule

// File: rtl/rtype_multicycle_sequencer.sv
// FETCH/DECODE/EXEC/WB sequencer for R-type instructions. Owns the IR, the fetch
// timeout counter and the retired counter; all strobes are decoded from state.
module rtype_multicycle_sequencer
    import rtype_pkg::*;
#(
    parameter int COUNT_W         = 16,
    parameter int FETCH_TIMEOUT   = 15,
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    rtype_multicycle_sequencer_if.master  imem,
    output logic [4:0]                    rs,
    output logic [4:0]                    rt,
    output logic [4:0]                    rd,
    output logic                          rf_read_en,
    output logic                          alu_en,
    output logic [3:0]                    ALUCntl,
    output logic                          RegWrite,
    output logic                          illegal,
    output logic                          fetch_err,
    output logic                          halted,
    output logic [COUNT_W-1:0]            retired
);

    localparam logic [2:0] S_FETCH  = ST_FETCH;
    localparam logic [2:0] S_DECODE = ST_DECODE;
    localparam logic [2:0] S_EXEC   = ST_EXEC;
    localparam logic [2:0] S_WB     = ST_WB;
    localparam logic [2:0] S_HALT   = ST_HALT;

    // Compare against the pre-increment value so the FETCH_TIMEOUT-th waiting cycle halts.
    localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

    logic [2:0]  state, state_nxt;
    logic [31:0] ir;
    logic [7:0]  tcnt;
    logic        legal_q;
    logic [3:0]  alu_q;
    logic        dec_legal;
    logic [3:0]  dec_alu;
    logic        fire, wait_cyc, tmo;
    logic        unused_shamt;

    assign rs = ir[25:21];
    assign rt = ir[20:16];
    assign rd = ir[15:11];
    assign unused_shamt = ^ir[10:6];

    rtype_decode u_decode (
        .op      (ir[31:26]),
        .func    (ir[5:0]),
        .legal   (dec_legal),
        .ALUCntl (dec_alu)
    );

    // An ack is only honoured while the request is actually up.
    assign imem.imem_req = (state == S_FETCH) && run;
    assign fire          = imem.imem_req && imem.imem_ack;
    assign wait_cyc      = imem.imem_req && !imem.imem_ack;
    assign tmo           = wait_cyc && (tcnt == TMO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (fire) state_nxt = S_DECODE;
                      else if (tmo) state_nxt = S_HALT;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   if (legal_q) state_nxt = S_WB;
                      else if (HALT_ON_ILLEGAL != 0) state_nxt = S_HALT;
                      else state_nxt = S_FETCH;
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            ir        <= '0;
            tcnt      <= '0;
            legal_q   <= 1'b0;
            alu_q     <= '0;
            fetch_err <= 1'b0;
            retired   <= '0;
        end else begin
            state <= state_nxt;
            if (fire) begin
                ir   <= imem.imem_data;
                tcnt <= '0;
            end else if (wait_cyc) begin
                tcnt <= tcnt + 8'd1;
            end
            if (tmo)
                fetch_err <= 1'b1;
            if (state == S_DECODE) begin
                legal_q <= dec_legal;
                alu_q   <= dec_alu;
            end
            // Writes to $zero are dropped but still retire.
            if ((state == S_WB) && (retired != {COUNT_W{1'b1}}))
                retired <= retired + COUNT_W'(1);
        end
    end

    assign rf_read_en = (state == S_DECODE);
    assign alu_en     = (state == S_EXEC) && legal_q;
    assign illegal    = (state == S_EXEC) && !legal_q;
    assign RegWrite   = (state == S_WB) && (rd != 5'd0);
    assign halted     = (state == S_HALT);
    assign ALUCntl    = (alu_en || (state == S_WB)) ? alu_q : 4'b0000;

endmodule

// File: tb/tb_rtype_multicycle_sequencer.sv
// Directed bench: u0 skips illegal instructions, u1 halts on them.
module tb_rtype_multicycle_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic run0, run1;
    always #5 clk = ~clk;

    rtype_multicycle_sequencer_if b0 ();
    rtype_multicycle_sequencer_if b1 ();

    logic [4:0]  rs0, rt0, rd0, rs1, rt1, rd1;
    logic        rf0, ae0, we0, ill0, ferr0, hlt0;
    logic        rf1, ae1, we1, ill1, ferr1, hlt1;
    logic [3:0]  alu0, alu1;
    logic [15:0] ret0_o, ret1_o;

    rtype_multicycle_sequencer #(.COUNT_W(16), .FETCH_TIMEOUT(15), .HALT_ON_ILLEGAL(0)) u0 (
        .clk(clk), .reset(reset), .run(run0), .imem(b0.master),
        .rs(rs0), .rt(rt0), .rd(rd0), .rf_read_en(rf0), .alu_en(ae0), .ALUCntl(alu0),
        .RegWrite(we0), .illegal(ill0), .fetch_err(ferr0), .halted(hlt0), .retired(ret0_o));

    rtype_multicycle_sequencer #(.COUNT_W(16), .FETCH_TIMEOUT(15), .HALT_ON_ILLEGAL(1)) u1 (
        .clk(clk), .reset(reset), .run(run1), .imem(b1.master),
        .rs(rs1), .rt(rt1), .rd(rd1), .rf_read_en(rf1), .alu_en(ae1), .ALUCntl(alu1),
        .RegWrite(we1), .illegal(ill1), .fetch_err(ferr1), .halted(hlt1), .retired(ret1_o));

    int n_tests = 0;
    int n_fail  = 0;
    int ret0    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One instruction on u0 with zero-wait ack; starts and ends in FETCH just after a rising edge.
    task automatic issue(input logic [31:0] instr, input logic [3:0] alu, input bit legal);
        run0 = 1'b1; b0.imem_ack = 1'b1; b0.imem_data = instr; #1;
        chk("req_fetch", b0.imem_req, 1);
        @(posedge clk); #1; b0.imem_ack = 1'b0; #1;
        chk("rf_read_en", rf0, 1);
        chk("req_decode", b0.imem_req, 0);
        chk("rd_field", rd0, instr[15:11]);
        @(posedge clk); #1;
        if (legal) begin
            chk("alu_en_exec", ae0, 1);
            chk("alu_exec", alu0, alu);
            chk("illegal_exec", ill0, 0);
            @(posedge clk); #1;
            chk("regwrite_wb", we0, (instr[15:11] != 5'd0));
            chk("alu_wb", alu0, alu);
            chk("alu_en_wb", ae0, 0);
            chk("retired_wb", ret0_o, ret0);
            ret0++;
        end else begin
            chk("illegal_exec", ill0, 1);
            chk("alu_en_ill", ae0, 0);
            chk("alu_ill", alu0, 0);
        end
        @(posedge clk); #1;
        chk("illegal_after", ill0, 0);
        chk("regwrite_after", we0, 0);
        chk("halted_after", hlt0, 0);
        chk("retired_after", ret0_o, ret0);
    endtask

    logic [5:0] fn  [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [3:0] acn [10] = '{4'b1010, 4'b0010, 4'b1110, 4'b0110, 4'b0000,
                             4'b0001, 4'b0011, 4'b1100, 4'b0101, 4'b1111};

    initial begin
        reset = 1'b1; run0 = 1'b0; run1 = 1'b0;
        b0.imem_ack = 1'b0; b0.imem_data = '0;
        b1.imem_ack = 1'b0; b1.imem_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", b0.imem_req, 0);
        chk("rst_rs", rs0, 0);
        chk("rst_strobes", {rf0, ae0, we0, ill0, ferr0, hlt0}, 0);
        chk("rst_alu", alu0, 0);
        chk("rst_retired", ret0_o, 0);
        @(posedge clk); #1; reset = 1'b0;

        // add $8,$9,$10
        issue(32'h012A4020, 4'b1010, 1'b1);
        chk("add_rs", rs0, 9);
        chk("add_rt", rt0, 10);

        for (int i = 0; i < 10; i++)
            issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn[i]}, acn[i], 1'b1);
        chk("sweep_retired", ret0_o, 11);

        // lw: Op=0x23 is not R-type
        issue(32'h8D280004, 4'b0000, 1'b0);
        chk("ill_retired", ret0_o, 11);

        // add $0,$9,$10: write suppressed, still retires
        issue(32'h012A0020, 4'b1010, 1'b1);
        chk("rd0_retired", ret0_o, 12);

        // sub $12,$10,$11 with run dropped in EXEC
        run0 = 1'b1; b0.imem_ack = 1'b1; b0.imem_data = 32'h014B6022;
        @(posedge clk); #1; b0.imem_ack = 1'b0;
        @(posedge clk); #1; run0 = 1'b0; #1;
        chk("rundrop_alu_en", ae0, 1);
        @(posedge clk); #1;
        chk("rundrop_wb", we0, 1);
        chk("rundrop_alu_wb", alu0, 4'b1110);
        @(posedge clk); #1;
        chk("rundrop_req", b0.imem_req, 0);
        chk("rundrop_retired", ret0_o, 13);
        ret0 = 13;

        // ack with no request is ignored
        b0.imem_ack = 1'b1; b0.imem_data = 32'h012A4020;
        repeat (2) @(posedge clk);
        #1;
        chk("stray_ack_rf", rf0, 0);
        chk("stray_ack_req", b0.imem_req, 0);
        b0.imem_ack = 1'b0;

        // ack arrives on the 14th waiting cycle
        run0 = 1'b1;
        repeat (13) @(posedge clk);
        #1;
        chk("wait13_halted", hlt0, 0);
        issue(32'h012A4020, 4'b1010, 1'b1);
        chk("late_ack_ferr", ferr0, 0);

        // ack withheld: 15 waiting cycles then HALT
        b0.imem_ack = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("tmo14_halted", hlt0, 0);
        chk("tmo14_req", b0.imem_req, 1);
        @(posedge clk); #1;
        chk("tmo_halted", hlt0, 1);
        chk("tmo_ferr", ferr0, 1);
        chk("tmo_req", b0.imem_req, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("tmo_sticky", {ferr0, hlt0}, 2'b11);
        reset = 1'b1; #1;
        chk("tmo_rst_halted", hlt0, 0);
        chk("tmo_rst_ferr", ferr0, 0);
        @(posedge clk); #1; reset = 1'b0; ret0 = 0;

        // reset asserted in WB
        run0 = 1'b1; b0.imem_ack = 1'b1; b0.imem_data = 32'h012A4020;
        @(posedge clk); #1; b0.imem_ack = 1'b0; run0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("wbrst_pre", we0, 1);
        reset = 1'b1; #1;
        chk("wbrst_we", we0, 0);
        chk("wbrst_alu", alu0, 0);
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;
        chk("wbrst_retired", ret0_o, 0);
        chk("wbrst_we_after", we0, 0);

        // u1: illegal instruction halts until reset
        run1 = 1'b1; b1.imem_ack = 1'b1; b1.imem_data = 32'h8D280004; #1;
        chk("h_req", b1.imem_req, 1);
        @(posedge clk); #1; b1.imem_ack = 1'b0; #1;
        chk("h_rf", rf1, 1);
        @(posedge clk); #1;
        chk("h_illegal", ill1, 1);
        chk("h_alu", alu1, 0);
        @(posedge clk); #1;
        chk("h_halted", hlt1, 1);
        chk("h_illegal_off", ill1, 0);
        b1.imem_ack = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("h_persist", hlt1, 1);
        chk("h_quiet", {b1.imem_req, rf1, ae1, we1, ill1}, 0);
        chk("h_retired", ret1_o, 0);
        reset = 1'b1; #1;
        chk("h_rst", hlt1, 0);
        @(posedge clk); #1; reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rtype_multicycle_sequencer.md
Name: rtype_multicycle_sequencer

Overview:
- Multi-cycle sequencer for the R-type execution datapath.
- Fetches a 32-bit instruction over a req/ack handshake and latches it into an internal IR.
- Decodes Op/Func into a 4-bit ALU control code, then steps the register file, ALU and writeback through fixed phases.
- Sits between instruction memory and the register-file/ALU datapath, replacing a purely combinational decode with a sequenced FETCH/DECODE/EXEC/WB flow.

Parameters:
- COUNT_W, 16, width of the retired-instruction counter; the counter saturates at all-ones.
- FETCH_TIMEOUT, 15, maximum cycles to wait for imem_ack before a fetch error (legal range 1..255).
- HALT_ON_ILLEGAL, 0, 1 = enter HALT on an illegal instruction; 0 = skip it and continue.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- run  in  1  level enable; a new fetch starts only while run=1.
- imem_req  out  1  fetch request; held high until ack or timeout.
- imem_ack  in  1  memory ack; imem_data is valid in the same cycle.
- imem_data  in  32  instruction word.
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- rf_read_en  out  1  register-file read strobe.
- alu_en  out  1  ALU operand/result capture strobe.
- ALUCntl  out  4  ALU operation code.
- RegWrite  out  1  register-file write strobe.
- illegal  out  1  one-cycle pulse on an unsupported instruction.
- fetch_err  out  1  sticky; set on fetch timeout.
- halted  out  1  high while in HALT.
- retired  out  COUNT_W  count of instructions completed with writeback.

Behaviour:
- Reset values: state=FETCH; IR=0; timeout counter=0; retired=0; all strobes, ALUCntl, illegal, fetch_err and halted = 0.
- rs/rt/rd are driven from IR at all times.
- States: FETCH, DECODE, EXEC, WB, HALT.
- FETCH:
  - imem_req = run.
  - On a cycle with req & ack: load IR from imem_data, clear the timeout counter, go to DECODE.
  - On a cycle with req & !ack: increment the timeout counter. When it reaches FETCH_TIMEOUT: set fetch_err, go to HALT.
  - With run=0: stay in FETCH, req=0, counter held.
- DECODE:
  - rf_read_en=1.
  - Decode is combinational from IR and registered as legal_q / alu_q.
  - Legal only when Op=IR[31:26]=0 and Func=IR[5:0] is one of:
    - 0x20→1010, 0x21→0010, 0x22→1110, 0x23→0110
    - 0x24→0000, 0x25→0001, 0x26→0011, 0x27→1100
    - 0x2A→0101, 0x2B→1111
  - Always go to EXEC.
- EXEC:
  - If legal_q: alu_en=1, ALUCntl=alu_q, go to WB.
  - If illegal: ALUCntl=0000, illegal=1 for this cycle only. Go to HALT if HALT_ON_ILLEGAL=1, else to FETCH.
- WB:
  - ALUCntl is held at alu_q.
  - RegWrite=1 unless rd=0; a write to $zero is suppressed, but the instruction still counts as retired.
  - retired increments (saturating). Go to FETCH.
- HALT: absorbing state; exited only by reset. halted=1 and all other strobes are 0.
- Latency: a legal instruction with zero-wait ack takes 4 cycles from req to the end of WB. Back-to-back issue gives one instruction per 4 cycles.
- run deasserted mid-instruction: the current instruction completes, and the sequencer parks in FETCH.
- Ack arriving while req=0 is ignored.
- Asynchronous reset mid-instruction: all outputs drop immediately. No partial writeback, and retired is not incremented.

Decomposition:
- Package rtype_pkg holds:
  - the state enum;
  - FUNC_* constants (6-bit) and ALU_* constants (4-bit) for the ten operations;
  - the OP_RTYPE constant.
- One natural combinational sub-module, rtype_decode: inputs Op and Func; outputs legal and ALUCntl[3:0].
- The sequencer instantiates rtype_decode and owns the FSM, IR, timeout counter and retired counter.

Test Plan:
- Reset, then run=1, ack immediately, imem_data=0x012A4020 (add $8,$9,$10):
  - req high 1 cycle; rf_read_en in the next cycle; then alu_en with ALUCntl=1010; then RegWrite=1 with rd=8.
  - retired=1 exactly 4 cycles after the req cycle.
- Sweep all ten legal Func codes with Op=0:
  - ALUCntl matches the table in both EXEC and WB.
  - retired=10.
- imem_data=0x8D280004 (Op=0x23) with HALT_ON_ILLEGAL=0:
  - illegal pulses once in EXEC; no RegWrite; retired unchanged; returns to FETCH.
- Repeat with HALT_ON_ILLEGAL=1: halted=1 persists until reset.
- Legal instruction with rd=0: RegWrite stays 0 and retired still increments.
- Ack withheld with FETCH_TIMEOUT=15:
  - fetch_err=1 and halted=1 after 15 req cycles.
  - A second case acks on cycle 14 of waiting and proceeds normally with fetch_err=0.
- Drop run during EXEC: WB completes and then req=0.
- Assert reset during WB: RegWrite falls without waiting for a clock edge and retired is not incremented.
